// File: rtl/updn_count_monitor_pkg.sv
// -----------------------------------------------------------------------------
// updn_count_monitor_pkg
// Shared definitions for the up/down counter bus monitor:
//   - default bus / wrap-counter widths
//   - step-direction encodings driven on DIR
//   - tracking FSM state encodings
//   - small helper to test whether a classified step is legal
// -----------------------------------------------------------------------------
package updn_count_monitor_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_WRAPW = 8;

  typedef enum logic [1:0] {
    DIR_HOLD = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DN   = 2'b10,
    DIR_BAD  = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  // Hold, up and down are legal; only the illegal code is not.
  function automatic logic step_is_legal(input dir_e step);
    return (step != DIR_BAD);
  endfunction

endpackage

// File: rtl/updn_step_class.sv
// -----------------------------------------------------------------------------
// updn_step_class
// Combinational classifier comparing the previous sample with the new one,
// modulo 2**WIDTH.
// Ports:
//   prev_i     in  WIDTH  previous enabled sample
//   q_i        in  WIDTH  current sample
//   step_o     out 2      DIR_HOLD / DIR_UP / DIR_DN / DIR_BAD
//   wrap_up_o  out 1      step is max -> 0 (implies DIR_UP)
//   wrap_dn_o  out 1      step is 0 -> max (implies DIR_DN)
// -----------------------------------------------------------------------------
module updn_step_class
  import updn_count_monitor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] prev_i,
  input  logic [WIDTH-1:0] q_i,
  output dir_e             step_o,
  output logic             wrap_up_o,
  output logic             wrap_dn_o
);

  // Neighbour codes of prev_i; WIDTH-bit arithmetic gives the modulo wrap.
  logic [WIDTH-1:0] next_up_s;
  logic [WIDTH-1:0] next_dn_s;

  assign next_up_s = prev_i + WIDTH'(1);
  assign next_dn_s = prev_i - WIDTH'(1);

  // Classify the step and flag the two wrap-around transitions.
  always_comb begin
    step_o    = DIR_BAD;
    wrap_up_o = 1'b0;
    wrap_dn_o = 1'b0;
    if (q_i == prev_i) begin
      step_o = DIR_HOLD;
    end else if (q_i == next_up_s) begin
      step_o    = DIR_UP;
      wrap_up_o = (q_i == {WIDTH{1'b0}});
    end else if (q_i == next_dn_s) begin
      step_o    = DIR_DN;
      wrap_dn_o = (q_i == {WIDTH{1'b1}});
    end else begin
      step_o = DIR_BAD;
    end
  end

endmodule

// File: rtl/updn_count_monitor.sv
// -----------------------------------------------------------------------------
// updn_count_monitor
// Receiving-end monitor for an up/down counter bus. Recovers the step
// direction from consecutive enabled samples, reports wrap-around events,
// keeps a net wrap count and flags illegal jumps, relocking after two
// consecutive legal steps.
// Ports:
//   CLK      in  1      rising-edge clock
//   RESETN   in  1      synchronous active-low reset
//   EN       in  1      sample enable
//   CLR      in  1      synchronous clear of ERR and WRAPS
//   Q_IN     in  WIDTH  observed count value
//   DIR      out 2      last step: 00 hold, 01 up, 10 down, 11 illegal
//   WRAP_UP  out 1      one-cycle pulse on max -> 0 up step
//   WRAP_DN  out 1      one-cycle pulse on 0 -> max down step
//   WRAPS    out WRAPW  net wrap count, modulo 2**WRAPW
//   LOCKED   out 1      high while tracking legal steps
//   ERR      out 1      sticky illegal-step flag
// All outputs are registered.
// -----------------------------------------------------------------------------
module updn_count_monitor
  import updn_count_monitor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int WRAPW = DEF_WRAPW
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             EN,
  input  logic             CLR,
  input  logic [WIDTH-1:0] Q_IN,
  output logic [1:0]       DIR,
  output logic             WRAP_UP,
  output logic             WRAP_DN,
  output logic [WRAPW-1:0] WRAPS,
  output logic             LOCKED,
  output logic             ERR
);

  state_e           state_q,   state_d;
  logic [WIDTH-1:0] prev_q,    prev_d;
  logic [1:0]       good_q,    good_d;
  dir_e             dir_q,     dir_d;
  logic             wrap_up_q, wrap_up_d;
  logic             wrap_dn_q, wrap_dn_d;
  logic [WRAPW-1:0] wraps_q,   wraps_d;
  logic             locked_q,  locked_d;
  logic             err_q,     err_d;

  dir_e             step_s;
  logic             step_wrap_up_s;
  logic             step_wrap_dn_s;
  logic             bad_s;
  logic [WRAPW-1:0] wraps_nxt_s;

  updn_step_class #(
    .WIDTH (WIDTH)
  ) u_step_class (
    .prev_i    (prev_q),
    .q_i       (Q_IN),
    .step_o    (step_s),
    .wrap_up_o (step_wrap_up_s),
    .wrap_dn_o (step_wrap_dn_s)
  );

  // Next-state, tracking and output decode for one enabled sample.
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    good_d      = good_q;
    dir_d       = DIR_HOLD;
    wrap_up_d   = 1'b0;
    wrap_dn_d   = 1'b0;
    locked_d    = locked_q;
    bad_s       = 1'b0;
    wraps_nxt_s = wraps_q;

    if (EN) begin
      prev_d = Q_IN;
      case (state_q)
        ST_INIT: begin
          // First sample has nothing to compare against.
          dir_d    = DIR_HOLD;
          state_d  = ST_TRACK;
          locked_d = 1'b1;
          good_d   = 2'd0;
        end
        ST_TRACK: begin
          dir_d = step_s;
          if (!step_is_legal(step_s)) begin
            bad_s    = 1'b1;
            locked_d = 1'b0;
            good_d   = 2'd0;
            state_d  = ST_FAULT;
          end else if (step_wrap_up_s) begin
            wrap_up_d   = 1'b1;
            wraps_nxt_s = wraps_q + WRAPW'(1);
          end else if (step_wrap_dn_s) begin
            wrap_dn_d   = 1'b1;
            wraps_nxt_s = wraps_q - WRAPW'(1);
          end else begin
            wraps_nxt_s = wraps_q;
          end
        end
        ST_FAULT: begin
          // Relocking: wraps are ignored, only run length of legal steps matters.
          dir_d = step_s;
          if (!step_is_legal(step_s)) begin
            bad_s  = 1'b1;
            good_d = 2'd0;
          end else if (good_q == 2'd1) begin
            good_d   = 2'd0;
            locked_d = 1'b1;
            state_d  = ST_TRACK;
          end else begin
            good_d = good_q + 2'd1;
          end
        end
        default: begin
          state_d  = ST_INIT;
          locked_d = 1'b0;
          good_d   = 2'd0;
        end
      endcase
    end else begin
      dir_d = DIR_HOLD;
    end

    // Clear discards any wrap this cycle; a fault detected now still sets ERR.
    if (CLR) begin
      wraps_d = {WRAPW{1'b0}};
      err_d   = bad_s;
    end else begin
      wraps_d = wraps_nxt_s;
      err_d   = err_q | bad_s;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q   <= ST_INIT;
      prev_q    <= {WIDTH{1'b0}};
      good_q    <= 2'd0;
      dir_q     <= DIR_HOLD;
      wrap_up_q <= 1'b0;
      wrap_dn_q <= 1'b0;
      wraps_q   <= {WRAPW{1'b0}};
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      good_q    <= good_d;
      dir_q     <= dir_d;
      wrap_up_q <= wrap_up_d;
      wrap_dn_q <= wrap_dn_d;
      wraps_q   <= wraps_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
    end
  end

  assign DIR     = dir_q;
  assign WRAP_UP = wrap_up_q;
  assign WRAP_DN = wrap_dn_q;
  assign WRAPS   = wraps_q;
  assign LOCKED  = locked_q;
  assign ERR     = err_q;

endmodule

// File: tb/tb_updn_count_monitor.sv
// -----------------------------------------------------------------------------
// tb_updn_count_monitor
// Scoreboard bench: each driven cycle updates a behavioural model and, after
// the clock edge, pushes the expected outputs into a queue; a monitor on the
// falling edge pops and compares against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_updn_count_monitor;

  logic       CLK;
  logic       RESETN;
  logic       EN;
  logic       CLR;
  logic [3:0] Q_IN;
  logic [1:0] DIR;
  logic       WRAP_UP;
  logic       WRAP_DN;
  logic [7:0] WRAPS;
  logic       LOCKED;
  logic       ERR;

  updn_count_monitor #(.WIDTH(4), .WRAPW(8)) dut (
    .CLK     (CLK),
    .RESETN  (RESETN),
    .EN      (EN),
    .CLR     (CLR),
    .Q_IN    (Q_IN),
    .DIR     (DIR),
    .WRAP_UP (WRAP_UP),
    .WRAP_DN (WRAP_DN),
    .WRAPS   (WRAPS),
    .LOCKED  (LOCKED),
    .ERR     (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int dir;
    int wu;
    int wd;
    int wraps;
    int locked;
    int err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state (integers, modulo arithmetic).
  int m_prev;
  bit m_have;
  bit m_track;
  int m_good;
  int m_wraps;
  int m_err;
  int m_dir;
  int m_wu;
  int m_wd;
  int last_q;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model(input bit rstn, input bit en, input bit clr, input int q);
    int d;
    bit bad;
    bad = 1'b0;
    if (!rstn) begin
      m_prev = 0; m_have = 0; m_track = 0; m_good = 0;
      m_wraps = 0; m_err = 0; m_dir = 0; m_wu = 0; m_wd = 0;
    end else begin
      m_dir = 0; m_wu = 0; m_wd = 0;
      if (en) begin
        if (!m_have) begin
          m_have = 1; m_track = 1; m_good = 0;
        end else begin
          d = (q - m_prev + 16) % 16;
          if (d == 0)       m_dir = 0;
          else if (d == 1)  m_dir = 1;
          else if (d == 15) m_dir = 2;
          else begin m_dir = 3; bad = 1'b1; end
          if (bad) begin
            m_err = 1; m_good = 0; m_track = 0;
          end else if (m_track) begin
            if (d == 1 && q == 0)   begin m_wu = 1; m_wraps = (m_wraps + 1) % 256; end
            if (d == 15 && q == 15) begin m_wd = 1; m_wraps = (m_wraps + 255) % 256; end
          end else begin
            m_good++;
            if (m_good >= 2) begin m_track = 1; m_good = 0; end
          end
        end
        m_prev = q;
      end
      if (clr) begin
        m_wraps = 0;
        if (!bad) m_err = 0;
      end
    end
  endtask

  task automatic step(input bit rstn, input bit en, input bit clr, input int q);
    exp_t e;
    RESETN = rstn; EN = en; CLR = clr; Q_IN = q[3:0];
    last_q = q % 16;
    model(rstn, en, clr, q % 16);
    e.dir = m_dir; e.wu = m_wu; e.wd = m_wd; e.wraps = m_wraps;
    e.locked = m_track ? 1 : 0; e.err = m_err;
    @(posedge CLK);
    exp_q.push_back(e);
    #1;
  endtask

  // Monitor: outputs are valid every cycle; compare against the oldest expectation.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("dir",     int'(DIR),     mon_e.dir);
      chk("wrap_up", int'(WRAP_UP), mon_e.wu);
      chk("wrap_dn", int'(WRAP_DN), mon_e.wd);
      chk("wraps",   int'(WRAPS),   mon_e.wraps);
      chk("locked",  int'(LOCKED),  mon_e.locked);
      chk("err",     int'(ERR),     mon_e.err);
    end
  end

  initial begin
    int r;
    int q;
    RESETN = 1'b0; EN = 1'b0; CLR = 1'b0; Q_IN = 4'd0;
    last_q = 0;
    model(1'b0, 1'b0, 1'b0, 0);

    // Reset with EN/CLR asserted: reset must win.
    step(0, 1, 1, 9);
    step(0, 0, 0, 0);

    // First samples and up steps.
    step(1, 1, 0, 3);
    step(1, 1, 0, 4);
    step(1, 1, 0, 5);
    for (int v = 6; v <= 15; v++) step(1, 1, 0, v);
    step(1, 1, 0, 0);      // wrap up
    step(1, 1, 0, 1);
    step(1, 1, 0, 1);      // hold
    step(1, 1, 0, 0);
    step(1, 1, 0, 15);     // wrap down
    for (int v = 14; v >= 6; v--) step(1, 1, 0, v);

    // Illegal jump, relock, wraps ignored while faulted.
    step(1, 1, 0, 9);
    step(1, 1, 0, 10);
    step(1, 1, 0, 10);
    step(1, 1, 0, 11);
    step(1, 1, 0, 2);      // illegal
    step(1, 1, 0, 3);
    step(1, 1, 0, 3);      // relocked at 3
    step(1, 1, 0, 2);

    // EN low holds PREV while the bus moves.
    step(1, 0, 0, 4);
    step(1, 0, 0, 5);
    step(1, 0, 0, 7);
    step(1, 1, 0, 7);      // 2 -> 7 illegal
    step(1, 1, 0, 8);
    step(1, 1, 0, 9);      // relocked

    // Build up five wraps, then clear with ERR set.
    q = 9;
    for (int i = 0; i < 5 * 16; i++) begin
      q = (q + 1) % 16;
      step(1, 1, 0, q);
    end
    step(1, 1, 1, q);      // CLR: ERR and WRAPS to 0
    while (q != 15) begin
      q = (q + 1) % 16;
      step(1, 1, 0, q);
    end
    step(1, 1, 1, 0);      // CLR with wrap up
    step(1, 1, 1, 8);      // CLR with illegal step
    step(1, 1, 0, 3);      // still faulted
    step(0, 1, 0, 4);      // reset mid-fault
    step(1, 1, 0, 12);
    step(1, 1, 0, 13);

    // Randomized traffic biased towards legal steps.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 30)      q = last_q;
      else if (r < 60) q = (last_q + 1) % 16;
      else if (r < 88) q = (last_q + 15) % 16;
      else             q = $urandom_range(0, 15);
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 99) < 85),
           ($urandom_range(0, 99) < 4),
           q);
    end

    step(1, 0, 0, last_q);
    repeat (2) @(negedge CLK);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
